// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's request/grant and register-file signals.
// The slave modport is the arbiter's view; master is the requester/stall side.
interface wb_arbiter_if #(
    parameter int unsigned N_REQ      = 8,
    parameter int unsigned REG_ADDR_W = 5
);
    logic [N_REQ-1:0]            i_req_valid;
    logic [N_REQ*REG_ADDR_W-1:0] i_req_rd;
    logic                        i_wb_hold;
    logic [N_REQ-1:0]            o_req_ready;
    logic [2:0]                  o_mux_sel;
    logic                        o_wb_we;
    logic [REG_ADDR_W-1:0]       o_wb_rd;
    logic                        o_busy;

    modport master (
        output i_req_valid, i_req_rd, i_wb_hold,
        input  o_req_ready, o_mux_sel, o_wb_we, o_wb_rd, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_rd, i_wb_hold,
        output o_req_ready, o_mux_sel, o_wb_we, o_wb_rd, o_busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: grants one result producer per cycle and drives
// the result-mux select, register-file write enable/address and a retire pulse.
module wb_arbiter #(
    parameter int unsigned N_REQ       = 8,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter bit          FIXED_PRIO0 = 1'b0
) (
    input logic         clk,
    input logic         arstn,
    wb_arbiter_if.slave bus
);
    localparam int unsigned SelW = 3;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                state_q, state_d;
    logic [SelW-1:0]       grant_q, grant_d;
    logic [SelW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [SelW:0]         win;
    logic [N_REQ-1:0]      grant_oh;
    logic                  fire;
    logic [REG_ADDR_W-1:0] req_rd [N_REQ];

    // Returns {found, index}; search starts at ptr and wraps through the 3-bit index.
    function automatic logic [SelW:0] pick(input logic [N_REQ-1:0] valid,
                                           input logic [SelW-1:0]  ptr);
        logic [SelW:0]   res;
        logic [SelW-1:0] idx;
        res = '0;
        if (FIXED_PRIO0 && valid[0]) begin
            res = {1'b1, {SelW{1'b0}}};
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx = ptr + SelW'(k);
                if (valid[idx]) res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_rd[i] = bus.i_req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        end
    end

    assign grant_oh = N_REQ'(1) << grant_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rd_d     = rd_q;
        rr_ptr_d = rr_ptr_q;
        win      = '0;
        unique case (state_q)
            StIdle: begin
                win = pick(bus.i_req_valid, rr_ptr_q);
                if (win[SelW]) begin
                    state_d = StGrant;
                    grant_d = win[SelW-1:0];
                    rd_d    = req_rd[win[SelW-1:0]];
                end
            end
            StGrant: begin
                if (!bus.i_wb_hold) begin
                    // A fixed-priority win by requester 0 leaves the rotation untouched.
                    if (!(FIXED_PRIO0 && grant_q == '0)) rr_ptr_d = grant_q + SelW'(1);
                    win = pick(bus.i_req_valid & ~grant_oh, rr_ptr_d);
                    if (win[SelW]) begin
                        grant_d = win[SelW-1:0];
                        rd_d    = req_rd[win[SelW-1:0]];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            rd_q     <= rd_d;
        end
    end

    // Reset also masks the retire so an in-flight request is never acknowledged.
    assign fire = arstn && (state_q == StGrant) && !bus.i_wb_hold;

    assign bus.o_req_ready = fire ? grant_oh : '0;
    assign bus.o_wb_we     = fire && (rd_q != '0);
    assign bus.o_mux_sel   = grant_q;
    assign bus.o_wb_rd     = rd_q;
    assign bus.o_busy      = (state_q == StGrant);
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: two instances (round-robin and fixed-priority-0) checked
// every cycle against a behavioural model, plus directed literal scenarios.
module tb_wb_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            arstn;
    logic            hold;
    logic [1:0][7:0] valid;
    logic [1:0][39:0] rdv;
    logic [1:0][7:0] ready;
    logic [1:0][2:0] mux;
    logic [1:0]      we;
    logic [1:0][4:0] wrd;
    logic [1:0]      busy;
    logic [1:0][7:0] rdy_seen;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter_if bus0 ();
    wb_arbiter_if bus1 ();

    assign bus0.i_req_valid = valid[0];
    assign bus0.i_req_rd    = rdv[0];
    assign bus0.i_wb_hold   = hold;
    assign bus1.i_req_valid = valid[1];
    assign bus1.i_req_rd    = rdv[1];
    assign bus1.i_wb_hold   = hold;
    assign ready[0] = bus0.o_req_ready;
    assign mux[0]   = bus0.o_mux_sel;
    assign we[0]    = bus0.o_wb_we;
    assign wrd[0]   = bus0.o_wb_rd;
    assign busy[0]  = bus0.o_busy;
    assign ready[1] = bus1.o_req_ready;
    assign mux[1]   = bus1.o_mux_sel;
    assign we[1]    = bus1.o_wb_we;
    assign wrd[1]   = bus1.o_wb_rd;
    assign busy[1]  = bus1.o_busy;

    wb_arbiter #(.N_REQ(8), .REG_ADDR_W(5), .FIXED_PRIO0(1'b0)) u_dut0 (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus0.slave)
    );

    wb_arbiter #(.N_REQ(8), .REG_ADDR_W(5), .FIXED_PRIO0(1'b1)) u_dut1 (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus1.slave)
    );

    // Behavioural model: who holds the write-back path, with which rd, and where
    // the round-robin search will start next.
    typedef struct packed {
        logic       busy;
        logic [2:0] grant;
        logic [4:0] rd;
        logic [2:0] ptr;
    } mstate_t;

    mstate_t m [2];
    bit      model_on = 1'b0;

    function automatic int pick(logic [7:0] v, int ptr, bit prio0);
        if (prio0 && v[0]) return 0;
        for (int k = 0; k < 8; k++) begin
            if (v[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [4:0] rd_of(logic [39:0] r, int i);
        return r[i*5 +: 5];
    endfunction

    function automatic mstate_t next_state(mstate_t s, logic rstn, logic hld,
                                           logic [7:0] v, logic [39:0] r, bit prio0);
        mstate_t n;
        int      w;
        int      np;
        n = s;
        if (!rstn) return '0;
        if (!s.busy) begin
            w = pick(v, int'(s.ptr), prio0);
            if (w >= 0) begin
                n.busy  = 1'b1;
                n.grant = 3'(w);
                n.rd    = rd_of(r, w);
            end
        end else if (!hld) begin
            np    = (prio0 && s.grant == 3'd0) ? int'(s.ptr) : (int'(s.grant) + 1) % 8;
            n.ptr = 3'(np);
            w     = pick(v & ~(8'h1 << s.grant), np, prio0);
            if (w >= 0) begin
                n.grant = 3'(w);
                n.rd    = rd_of(r, w);
            end else begin
                n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!arstn) model_on <= 1'b1;
        for (int d = 0; d < 2; d++) begin
            m[d] <= next_state(m[d], arstn, hold, valid[d], rdv[d], d == 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic live(mstate_t s, logic rstn, logic hld);
        return rstn && !hld && s.busy;
    endfunction

    always @(negedge clk) begin
        rdy_seen <= ready;
        if (model_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d ready", d), 32'(ready[d]),
                    32'(live(m[d], arstn, hold) ? (8'h1 << m[d].grant) : 8'h0));
                chk($sformatf("dut%0d we", d), 32'(we[d]),
                    32'(live(m[d], arstn, hold) && m[d].rd != 5'd0));
                chk($sformatf("dut%0d mux_sel", d), 32'(mux[d]), 32'(m[d].grant));
                chk($sformatf("dut%0d wb_rd", d), 32'(wrd[d]), 32'(m[d].rd));
                chk($sformatf("dut%0d busy", d), 32'(busy[d]), 32'(m[d].busy));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        valid = '0;
        tick();
        arstn = 1'b1;
    endtask

    initial begin
        logic [4:0] rv;
        arstn = 1'b0;
        hold  = 1'b0;
        valid = '0;
        rdv   = '0;

        // Reset with every requester pending, then fairness sweep on the RR instance.
        valid = {8'hFF, 8'hFF};
        for (int i = 0; i < 8; i++) begin
            rdv[0][i*5 +: 5] = 5'(i + 1);
            rdv[1][i*5 +: 5] = 5'(i + 1);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            chk("reset ready0", 32'(ready[0]), 32'h0);
            chk("reset ready1", 32'(ready[1]), 32'h0);
            chk("reset mux0", 32'(mux[0]), 32'h0);
            chk("reset we0", 32'(we[0]), 32'h0);
            chk("reset rd0", 32'(wrd[0]), 32'h0);
            chk("reset busy0", 32'(busy[0]), 32'h0);
        end
        arstn = 1'b1;
        tick();
        #1;
        chk("post-reset mux0", 32'(mux[0]), 32'h0);
        chk("post-reset ready0", 32'(ready[0]), 32'h01);
        chk("post-reset ready1", 32'(ready[1]), 32'h01);
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            chk($sformatf("rr grant %0d", k), 32'(mux[0]), 32'(k % 8));
            chk($sformatf("rr ready %0d", k), 32'(ready[0]), 32'(8'h1 << (k % 8)));
            chk($sformatf("rr rd %0d", k), 32'(wrd[0]), 32'((k % 8) + 1));
        end

        // Single request from requester 3 with rd 10.
        do_reset();
        valid[0] = 8'h08;
        rdv[0][15 +: 5] = 5'd10;
        tick();
        #1;
        chk("single mux", 32'(mux[0]), 32'd3);
        chk("single we", 32'(we[0]), 32'd1);
        chk("single rd", 32'(wrd[0]), 32'd10);
        chk("single ready", 32'(ready[0]), 32'h08);
        tick();
        valid[0] = 8'h00;
        #1;
        chk("single idle busy", 32'(busy[0]), 32'd0);
        chk("single idle we", 32'(we[0]), 32'd0);
        chk("single idle mux kept", 32'(mux[0]), 32'd3);

        // Hold for 3 cycles during requester 2's grant, requester 5 waiting.
        do_reset();
        valid[0] = 8'h24;
        rdv[0][10 +: 5] = 5'd9;
        rdv[0][25 +: 5] = 5'd21;
        tick();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold mux", 32'(mux[0]), 32'd2);
            chk("hold we", 32'(we[0]), 32'd0);
            chk("hold ready", 32'(ready[0]), 32'h0);
            tick();
        end
        hold = 1'b0;
        #1;
        chk("hold release ready", 32'(ready[0]), 32'h04);
        chk("hold release rd", 32'(wrd[0]), 32'd9);
        tick();
        valid[0] = 8'h20;
        #1;
        chk("after hold mux", 32'(mux[0]), 32'd5);
        chk("after hold ready", 32'(ready[0]), 32'h20);
        chk("after hold rd", 32'(wrd[0]), 32'd21);
        tick();
        valid[0] = 8'h00;

        // Fixed priority on instance 1: requester 0 (rd 0) beats 6 (rd 7) with ptr at 4.
        do_reset();
        valid[1] = 8'h08;
        rdv[1][15 +: 5] = 5'd3;
        rdv[1][0 +: 5]  = 5'd0;
        rdv[1][30 +: 5] = 5'd7;
        tick();
        #1;
        chk("prio warmup ready", 32'(ready[1]), 32'h08);
        valid[1] = 8'h49;
        tick();
        valid[1] = 8'h41;
        #1;
        chk("prio0 mux", 32'(mux[1]), 32'd0);
        chk("prio0 ready", 32'(ready[1]), 32'h01);
        chk("prio0 x0 we", 32'(we[1]), 32'd0);
        tick();
        valid[1] = 8'h40;
        #1;
        chk("prio6 mux", 32'(mux[1]), 32'd6);
        chk("prio6 ready", 32'(ready[1]), 32'h40);
        chk("prio6 we", 32'(we[1]), 32'd1);
        chk("prio6 rd", 32'(wrd[1]), 32'd7);
        tick();
        valid[1] = 8'h00;
        #1;
        chk("model ptr after prio", 32'(m[1].ptr), 32'd7);

        // Reset while requester 4 is granted: no retire, re-granted after release.
        do_reset();
        valid[0] = 8'h10;
        rdv[0][20 +: 5] = 5'd12;
        tick();
        arstn = 1'b0;
        #1;
        chk("midreset ready", 32'(ready[0]), 32'h0);
        chk("midreset we", 32'(we[0]), 32'd0);
        chk("midreset mux", 32'(mux[0]), 32'd4);
        tick();
        #1;
        chk("midreset busy", 32'(busy[0]), 32'd0);
        chk("midreset mux cleared", 32'(mux[0]), 32'd0);
        chk("midreset ptr model", 32'(m[0].ptr), 32'd0);
        arstn = 1'b1;
        tick();
        #1;
        chk("regrant mux", 32'(mux[0]), 32'd4);
        chk("regrant ready", 32'(ready[0]), 32'h10);
        chk("regrant rd", 32'(wrd[0]), 32'd12);
        tick();
        valid[0] = 8'h00;
        tick();

        // Random traffic on both instances; requesters obey the hold-until-ready rule.
        for (int c = 0; c < 4000; c++) begin
            tick();
            arstn = ($urandom_range(0, 63) != 0);
            hold  = ($urandom_range(0, 3) == 0);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 8; i++) begin
                    rv = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                    if (!valid[d][i]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            valid[d][i]       = 1'b1;
                            rdv[d][i*5 +: 5]  = rv;
                        end
                    end else if (rdy_seen[d][i]) begin
                        if ($urandom_range(0, 1) == 0) valid[d][i] = 1'b0;
                        else rdv[d][i*5 +: 5] = rv;
                    end
                end
            end
        end
        arstn = 1'b1;
        hold  = 1'b0;
        valid = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the core's shared result path. Up to eight result producers (ALU, load unit, CSR, mul/div, PC+4, immediate, etc.) raise write-back requests; the block grants one per cycle by round-robin. It drives the 3-bit select of the 8-to-1 result mux, the register-file write enable and destination address, and a per-requester ready pulse that retires the request.

## Interface
- `N_REQ`, default 8: number of requesters. Fixed at 8 because the mux select is 3 bits.
- `REG_ADDR_W`, default 5: destination register address width.
- `FIXED_PRIO0`, default 0: when 1, requester 0 always wins if valid. Round-robin applies to requesters 1..7 only.

Ports:
- `clk`, in, 1: the single clock. Everything is on the rising edge.
- `arstn`, in, 1: reset, **synchronous, active-low**.
- `i_req_valid`, in, 8: per-requester request.
- `i_req_rd`, in, 8*REG_ADDR_W: destination address. Slice i is `[i*REG_ADDR_W +: REG_ADDR_W]`.
- `i_wb_hold`, in, 1: downstream stall. Freezes the current grant.
- `o_req_ready`, out, 8: one-hot. Pulses when requester i's result is retired.
- `o_mux_sel`, out, 3: select for the result mux (`control_signal`).
- `o_wb_we`, out, 1: register-file write enable.
- `o_wb_rd`, out, REG_ADDR_W: register-file write address.
- `o_busy`, out, 1: high in the GRANT state.

## Operation
- Requester protocol:
  - Assert `i_req_valid[i]`.
  - Hold `i_req_rd` slice i and its mux data input stable until `o_req_ready[i]` is seen.
  - In the cycle after ready, either drop valid or present a new request.
  - Dropping valid while granted is a protocol violation. The grant completes anyway.
- State machine, two states:
  - **IDLE**: if any valid bit is set, choose the winner, register `grant_idx` and `o_wb_rd`, then go to GRANT. Otherwise stay in IDLE.
  - **GRANT**:
    - `o_mux_sel = grant_idx`.
    - If `!i_wb_hold`: `o_req_ready[grant_idx]=1`, `o_wb_we = (o_wb_rd != 0)`, `rr_ptr <= grant_idx+1` (mod 8).
    - In that same cycle, re-arbitrate over `i_req_valid & ~(1<<grant_idx)`. If any remain, load the new grant and stay in GRANT. If none, go to IDLE.
    - If `i_wb_hold`: no ready, `o_wb_we=0`, and `grant_idx`, `o_wb_rd` and `rr_ptr` are all unchanged.
- Round-robin: the search starts at `rr_ptr` and wraps 7→0. The first valid requester found wins.
- `rr_ptr` advances only on retirement, never on a held grant.
- `FIXED_PRIO0=1`:
  - Requester 0 is checked first.
  - If it wins, `rr_ptr` is not updated.
- Destination x0: a request with rd==0 is granted and acknowledged, but `o_wb_we` stays 0.
- Reset (`arstn` low at an edge), including mid-grant:
  - state=IDLE, `rr_ptr`=0, `grant_idx`=0.
  - Outputs: `o_mux_sel`=0, `o_wb_rd`=0, `o_wb_we`=0, `o_req_ready`=0, `o_busy`=0.
  - The in-flight request is not retired. The requester keeps valid high and is re-arbitrated after reset.
- In IDLE:
  - `o_mux_sel` and `o_wb_rd` hold their last values, so the mux does not toggle.
  - `o_wb_we`=0 and `o_req_ready`=0.

## Timing
- Latency: valid sampled at edge t → GRANT in cycle t+1. In t+1, `o_mux_sel`, `o_wb_we`, `o_wb_rd` and `o_req_ready` are valid together, and the register file writes at edge t+2.
- `o_mux_sel`, `o_wb_rd` and `o_busy` come directly from registers.
- `o_wb_we` and `o_req_ready` are state/grant decoded and gated by `i_wb_hold` (one AND level).
- Throughput: one retirement per cycle while two or more requesters are pending.
- Single requester re-requesting:
  - It is masked in its ready cycle, so its next write is 2 cycles later.
  - Minimum spacing is ready at t+1, next ready at t+3.
- `i_wb_hold` asserted for k cycles extends GRANT by exactly k cycles.
- Simultaneous events:
  - Hold + reset: reset wins.
  - Valid arriving during a hold: waits; it is arbitrated in the cycle the hold drops.

## Test plan
- **Reset:** hold `arstn`=0 for 2 cycles with all valids high. Required: all outputs 0, `o_busy`=0. Release. Required: exactly one cycle later, `o_mux_sel`=0 and `o_req_ready`=8'h01.
- **Single request:** requester 3 valid with rd=5'd10 at cycle 0. Required in cycle 1: `o_mux_sel`=3, `o_wb_we`=1, `o_wb_rd`=10, `o_req_ready`=8'h08. Required in cycle 2: IDLE and `o_wb_we`=0.
- **Round-robin fairness:** all 8 valid continuously. Required: grants 0,1,…,7,0 on consecutive cycles, each `o_req_ready` one-hot, no idle cycles.
- **Hold:**
  - Setup: requesters 2 and 5 valid; assert `i_wb_hold` for 3 cycles during requester 2's grant.
  - During the hold: `o_mux_sel` stays 2, `o_wb_we`=0, no ready.
  - After the hold drops: ready 8'h04, then requester 5 granted the following cycle.
- **x0 and priority:**
  - `FIXED_PRIO0=1`, requester 0 (rd=0) and requester 6 (rd=7) valid.
  - Required: requester 0 acknowledged with `o_wb_we`=0, then requester 6 written with rd=7.
- **Reset mid-grant:** pull `arstn` low during requester 4's GRANT cycle. Required: no ready pulse, `rr_ptr`=0 after reset, and requester 4 re-granted after release.
